// File: rtl/cls_multiword_seq_pkg.sv
// Shared definitions for the word-serial subtractor: slice width, FSM encoding
// and the slice-offset helper.
package cls_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cls_seq_state_t;

  function automatic int slice_off(input int idx);
    return idx * SLICE_W;
  endfunction

endpackage

// File: rtl/cls_multiword_seq_if.sv
// Request/result bundle for cls_multiword_seq; the sat signal exists only
// when CLS_SAT_EN is defined.
interface cls_multiword_seq_if
  import cls_pkg::*;
#(
  parameter int WORDS = 4
);
  localparam int W = WORDS * SLICE_W;

  logic         start;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         zero;
`ifdef CLS_SAT_EN
  logic         sat;
`endif

  modport master (
    output start, in_a, in_b, bin,
    input  busy, done, diff, bout, zero
`ifdef CLS_SAT_EN
    , input sat
`endif
  );

  modport slave (
    input  start, in_a, in_b, bin,
    output busy, done, diff, bout, zero
`ifdef CLS_SAT_EN
    , output sat
`endif
  );

endinterface

// File: rtl/cls_multiword_seq_slice.sv
// cls_slice_unit: 16-bit carry-lookahead subtractor (CLS_16bit) plus the
// PG2B group borrow-out stage, purely combinational.
module cls_slice_unit
  import cls_pkg::*;
(
  input  logic [SLICE_W-1:0] a16,
  input  logic [SLICE_W-1:0] b16,
  input  logic               bin,
  output logic [SLICE_W-1:0] d16,
  output logic               bout
);

  logic [SLICE_W-1:0] p;   // borrow propagates when bits are equal
  logic [SLICE_W-1:0] g;   // borrow generated when a=0, b=1
  logic [SLICE_W-1:0] bw;  // borrow into each bit
  logic [3:0]         np;
  logic [3:0]         ng;
  logic [3:0]         nb;  // borrow into each nibble
  logic               gp;
  logic               gg;

  genvar gi;
  generate
    for (gi = 0; gi < SLICE_W; gi++) begin : g_bit
      assign p[gi]   = ~(a16[gi] ^ b16[gi]);
      assign g[gi]   = ~a16[gi] & b16[gi];
      assign d16[gi] = ~p[gi] ^ bw[gi];
    end

    // Lookahead across nibbles, short ripple inside each nibble.
    for (gi = 0; gi < 4; gi++) begin : g_nib
      assign np[gi] = &p[4*gi +: 4];
      assign ng[gi] = g[4*gi+3]
                    | (p[4*gi+3] & g[4*gi+2])
                    | (p[4*gi+3] & p[4*gi+2] & g[4*gi+1])
                    | (p[4*gi+3] & p[4*gi+2] & p[4*gi+1] & g[4*gi]);
      assign bw[4*gi]   = nb[gi];
      assign bw[4*gi+1] = g[4*gi]   | (p[4*gi]   & bw[4*gi]);
      assign bw[4*gi+2] = g[4*gi+1] | (p[4*gi+1] & bw[4*gi+1]);
      assign bw[4*gi+3] = g[4*gi+2] | (p[4*gi+2] & bw[4*gi+2]);
    end
  endgenerate

  assign nb[0] = bin;
  assign nb[1] = ng[0] | (np[0] & bin);
  assign nb[2] = ng[1] | (np[1] & ng[0]) | (np[1] & np[0] & bin);
  assign nb[3] = ng[2] | (np[2] & ng[1]) | (np[2] & np[1] & ng[0])
               | (np[2] & np[1] & np[0] & bin);

  assign gp = &np;
  assign gg = ng[3] | (np[3] & ng[2]) | (np[3] & np[2] & ng[1])
            | (np[3] & np[2] & np[1] & ng[0]);

  // PG2B
  assign bout = gg | (gp & bin);

endmodule

// File: rtl/cls_multiword_seq.sv
// Word-serial WORDS x 16-bit subtractor A - B - bin, one slice per clock,
// LSW first. Define CLS_SAT_EN for saturating unsigned subtract with a sat flag.
module cls_multiword_seq
  import cls_pkg::*;
#(
  parameter int WORDS = 4,
  parameter int IDXW  = 4
)(
  input logic                clk,
  input logic                rst,
  cls_multiword_seq_if.slave bus
);

  localparam int W = WORDS * SLICE_W;

  cls_seq_state_t     state_reg;
  logic [IDXW-1:0]    idx_reg;
  logic               borrow_reg;
  logic [W-1:0]       a_reg;
  logic [W-1:0]       b_reg;
  logic               bin_reg;
  logic               zero_acc_reg;
  logic [W-1:0]       diff_reg;
  logic               bout_reg;
  logic               zero_reg;
  logic               done_reg;
`ifdef CLS_SAT_EN
  logic               sat_reg;
`endif

  int                 off;
  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic               slice_bin;
  logic [SLICE_W-1:0] slice_d;
  logic               slice_bout;
  logic               slice_zero;
  logic               last_slice;

  assign off        = slice_off(int'(idx_reg));
  assign slice_a    = a_reg[off +: SLICE_W];
  assign slice_b    = b_reg[off +: SLICE_W];
  assign slice_bin  = (idx_reg == '0) ? bin_reg : borrow_reg;
  assign slice_zero = (slice_d == '0);
  assign last_slice = (idx_reg == IDXW'(WORDS - 1));

  cls_slice_unit u_slice (
    .a16  (slice_a),
    .b16  (slice_b),
    .bin  (slice_bin),
    .d16  (slice_d),
    .bout (slice_bout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      borrow_reg   <= 1'b0;
      a_reg        <= '0;
      b_reg        <= '0;
      bin_reg      <= 1'b0;
      zero_acc_reg <= 1'b0;
      diff_reg     <= '0;
      bout_reg     <= 1'b0;
      zero_reg     <= 1'b0;
      done_reg     <= 1'b0;
`ifdef CLS_SAT_EN
      sat_reg      <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            a_reg        <= bus.in_a;
            b_reg        <= bus.in_b;
            bin_reg      <= bus.bin;
            diff_reg     <= '0;
            idx_reg      <= '0;
            zero_acc_reg <= 1'b1;
            state_reg    <= RUN;
          end
        end
        RUN: begin
          diff_reg[off +: SLICE_W] <= slice_d;
          borrow_reg               <= slice_bout;
          zero_acc_reg             <= zero_acc_reg & slice_zero;
          if (last_slice) begin
            state_reg <= DONE;
            bout_reg  <= slice_bout;
            zero_reg  <= zero_acc_reg & slice_zero;
            done_reg  <= 1'b1;
`ifdef CLS_SAT_EN
            sat_reg   <= slice_bout;
            // Underflow clamps the whole result to zero.
            if (slice_bout) begin
              diff_reg <= '0;
              zero_reg <= 1'b1;
            end
`endif
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state_reg != IDLE);
  assign bus.done = done_reg;
  assign bus.diff = diff_reg;
  assign bus.bout = bout_reg;
  assign bus.zero = zero_reg;
`ifdef CLS_SAT_EN
  assign bus.sat  = sat_reg;
`endif

endmodule

// File: tb/tb_cls_multiword_seq.sv
// Scoreboard bench for cls_multiword_seq (WORDS=4): directed vectors, monitor
// pops expected results on every done pulse.
module tb_cls_multiword_seq;

  localparam int WORDS = 4;

  typedef struct {
    logic [63:0] diff;
    logic        bout;
    logic        zero;
    logic        sat;
  } exp_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  exp_t sb_q[$];
  exp_t mon_e;

  cls_multiword_seq_if #(.WORDS(WORDS)) bus ();

  cls_multiword_seq #(.WORDS(WORDS), .IDXW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] d, input logic b, input logic z, input logic s);
    exp_t e;
    e.diff = d;
    e.bout = b;
    e.zero = z;
    e.sat  = s;
    return e;
  endfunction

  // Monitor: one line per completed transaction.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL unexpected_done: got diff %h, required no result", bus.diff);
      end else begin
        mon_e = sb_q.pop_front();
        $display("[TB] result diff=%h bout=%0b zero=%0b", bus.diff, bus.bout, bus.zero);
        check("diff", bus.diff, mon_e.diff);
        check("bout", 64'(bus.bout), 64'(mon_e.bout));
        check("zero", 64'(bus.zero), 64'(mon_e.zero));
`ifdef CLS_SAT_EN
        check("sat", 64'(bus.sat), 64'(mon_e.sat));
`endif
      end
    end
  end

  // Issue one operation; optionally register its expected result and check latency.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic bi,
                        input exp_t e);
    int lat;
    @(negedge clk);
    bus.start = 1'b1;
    bus.in_a  = a;
    bus.in_b  = b;
    bus.bin   = bi;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.in_a  = ~a;  // must not affect the latched operands
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    check("latency", 64'(lat), 64'(WORDS));
    @(posedge clk);
    #1;
    check("busy_after_done", 64'(bus.busy), 64'd0);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.in_a  = '0;
    bus.in_b  = '0;
    bus.bin   = 1'b0;
    #13;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_diff", bus.diff, 64'd0);
    check("rst_bout", 64'(bus.bout), 64'd0);
    check("rst_zero", 64'(bus.zero), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(64'h0000_0001_0000_0000, 64'h1, 1'b0, mk(64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 1'b0));
`ifdef CLS_SAT_EN
    run_op(64'h0, 64'h0, 1'b1, mk(64'h0, 1'b1, 1'b1, 1'b1));
`else
    run_op(64'h0, 64'h0, 1'b1, mk(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0));
`endif
    run_op(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, mk(64'h0, 1'b0, 1'b1, 1'b0));
    run_op(64'h8000_0000_0000_0000, 64'h0000_0000_0001_0000, 1'b1,
           mk(64'h7FFF_FFFF_FFFE_FFFF, 1'b0, 1'b0, 1'b0));

    // Handshake: start held high, in_a changed during RUN.
    @(negedge clk);
    bus.start = 1'b1;
    bus.in_a  = 64'd100;
    bus.in_b  = 64'd1;
    bus.bin   = 1'b0;
    sb_q.push_back(mk(64'd99, 1'b0, 1'b0, 1'b0));
    sb_q.push_back(mk(64'd49, 1'b0, 1'b0, 1'b0));
    @(posedge clk);  // edge 0
    #1;
    bus.in_a = 64'd50;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
    end
    check("hs_done_edge4", 64'(bus.done), 64'd1);
    @(posedge clk);  // edge 5
    #1;
    check("hs_busy_edge5", 64'(bus.busy), 64'd0);
    @(posedge clk);  // edge 6
    #1;
    check("hs_busy_edge6", 64'(bus.busy), 64'd1);
    bus.start = 1'b0;
    begin
      int lat2;
      lat2 = 0;
      for (int k = 1; k <= 20; k++) begin
        @(posedge clk);
        #1;
        if (bus.done) begin
          lat2 = k;
          break;
        end
      end
      check("hs_latency2", 64'(lat2), 64'(WORDS));
    end
    @(posedge clk);
    #1;

    // Reset while idx=2; the aborted operation has no scoreboard entry.
    @(negedge clk);
    bus.start = 1'b1;
    bus.in_a  = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.in_b  = 64'd1;
    bus.bin   = 1'b0;
    @(posedge clk);  // edge 0
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_done", 64'(bus.done), 64'd0);
    check("mid_rst_diff", bus.diff, 64'd0);
    check("mid_rst_bout", 64'(bus.bout), 64'd0);
    check("mid_rst_zero", 64'(bus.zero), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(64'd10, 64'd3, 1'b0, mk(64'd7, 1'b0, 1'b0, 1'b0));

`ifdef CLS_SAT_EN
    run_op(64'd5, 64'd7, 1'b0, mk(64'h0, 1'b1, 1'b1, 1'b1));
`else
    run_op(64'd5, 64'd7, 1'b0, mk(64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0));
`endif

    repeat (4) @(posedge clk);
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

endmodule

// File: doc/cls_multiword_seq.md
Name: cls_multiword_seq

Overview:
Word-serial controller that sequences one 16-bit carry-lookahead subtractor (CLS_16bit plus PG2B borrow-out stage) to perform a WORDS×16-bit subtraction A − B − bin. Each clock cycle it steps through one 16-bit slice, least significant first, and chains the borrow through a register. It gives wide-operand users (multi-precision compare and subtract) a start/busy/done handshake, so the datapath does not need a full-width lookahead tree.

Parameters:
- WORDS, 4, number of 16-bit slices; operand width is WORDS*16; legal range 2..16.
- IDXW, 4, width of the slice index counter; must satisfy 2**IDXW ≥ WORDS.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- in_a  input  WORDS*16  minuend; latched on the accepted start.
- in_b  input  WORDS*16  subtrahend; latched on the accepted start.
- bin  input  1  initial borrow-in; latched on the accepted start.
- busy  output  1  high whenever state ≠ IDLE.
- done  output  1  one-cycle pulse; result is valid in that cycle.
- diff  output  WORDS*16  registered difference; holds its value until the next accepted start.
- bout  output  1  final borrow-out from the top slice.
- zero  output  1  high when the final diff is all zeros.

Behaviour:
- Reset (async, rst=1): state=IDLE, idx=0, borrow register=0; busy=0, done=0, diff=0, bout=0, zero=0; operand latches cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at a rising edge: latch in_a, in_b and bin; clear diff; set idx=0 and zero accumulator=1; go to RUN.
  - If start=0: stay in IDLE.
- RUN, each edge:
  - Slice operands are a[idx], b[idx].
  - Borrow-in to the CLS is the latched bin when idx=0, otherwise the borrow register.
  - Write the CLS output into diff[idx*16 +: 16].
  - Load the borrow register with PG2B(borrow_in, gp, gg).
  - AND the zero accumulator with (slice result == 0).
  - idx increments.
- RUN exit: on the edge that processes idx=WORDS-1, go to DONE. On that same edge register bout = final borrow, zero = accumulator, done=1.
- DONE: lasts exactly one cycle. done=1, busy=1. The next edge forces done=0 and returns to IDLE. start is ignored in DONE.
- Latency: result and done become visible after edge WORDS, counting the start-sampling edge as edge 0. Next start can be accepted at edge WORDS+2, so throughput is one operation per WORDS+2 cycles.
- start while busy: ignored and not queued. The requester must hold start (or reassert it) after busy falls.
- Operand changes on in_a, in_b or bin during RUN/DONE: no effect, because operands are latched.
- Arithmetic: unsigned, modulo 2**(WORDS*16).
  - {bout, diff} equals A − B − bin in (WORDS*16+1)-bit two's complement.
  - bout=1 exactly when A < B + bin.
- Wrap-around: idx never exceeds WORDS-1; it resets to 0 on accept.
- Reset mid-operation: immediate return to IDLE with all outputs at their reset values. The partial result is discarded.

Optional Feature:
- Macro: CLS_SAT_EN.
- Defined:
  - On the DONE transition, if the final borrow is 1, diff is forced to all zeros and zero=1 (saturating unsigned subtract). bout still reports 1.
  - Adds output port sat (1 bit), registered with done and high when saturation occurred; reset value 0.
- Undefined: diff is the raw modular result and port sat is absent.

Decomposition:
- Shared package cls_pkg holds:
  - localparam SLICE_W=16;
  - state encoding typedef cls_seq_state_t (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - helper function for the slice index offset (idx*SLICE_W).
- Datapath slice: the existing CLS_16bit and PG2B instances are wrapped in one sub-module, cls_slice_unit.
  - Inputs: a16, b16, bin.
  - Outputs: d16, bout.
  - The controller instantiates exactly one cls_slice_unit; all sequencing stays in cls_multiword_seq.

Test Plan:
- Cross-word borrow: WORDS=4, A=64'h0000_0001_0000_0000, B=64'h1, bin=0 → done high exactly after edge 4; diff=64'h0000_0000_FFFF_FFFF; bout=0, zero=0.
- Full underflow: A=0, B=0, bin=1 → diff=64'hFFFF_FFFF_FFFF_FFFF, bout=1, zero=0.
- Equal operands: A=B=64'h1234_5678_9ABC_DEF0, bin=0 → diff=0, bout=0, zero=1.
- Handshake: hold start=1 throughout and change in_a during RUN → first result uses the latched operands; second accept occurs at edge 6; busy low for exactly one cycle (IDLE) between the two operations.
- Reset mid-run: assert rst while idx=2 → busy, done, diff, bout and zero all 0 immediately. A following start with A=10, B=3 gives diff=7, bout=0.
- A=5, B=7, bin=0:
  - without CLS_SAT_EN: diff=64'hFFFF_FFFF_FFFF_FFFE, bout=1;
  - with CLS_SAT_EN: diff=0, zero=1, bout=1, sat=1.
